// File: rtl/jpeg_pkg.sv
// jpeg_pkg: shared block geometry, pixel layout and read-state type for the JPEG front end
package jpeg_pkg;
   localparam int BLOCK_PIXELS = 64;
   localparam int BLOCK_DIM = 8;
   localparam logic [7:0] LEVEL_OFFSET = 8'd128;
   typedef struct packed {
      logic [7:0] cr;
      logic [7:0] cb;
      logic [7:0] y;
   } ycbcr_pixel_t;
   typedef enum logic {IDLE, STREAM} rd_state_t;
endpackage

// File: rtl/block_addr_gen.sv
// block_addr_gen: maps a replay count to the raster address within an 8x8 block
module block_addr_gen
   import jpeg_pkg::*;
#(
   parameter bit READ_ORDER = 1'b0
) (
   input  logic [5:0] cnt,
   output logic [5:0] addr,
   output logic       last
);
   always_comb begin
      addr = READ_ORDER ? {cnt[2:0], cnt[5:3]} : cnt;
      last = cnt == 6'(BLOCK_PIXELS - 1);
   end
endmodule

// File: rtl/ycbcr_block_buffer.sv
// ycbcr_block_buffer: ping-pong 8x8 YCbCr block store replaying blocks to the DCT stages
module ycbcr_block_buffer
   import jpeg_pkg::*;
#(
   parameter bit LEVEL_SHIFT = 1'b1,
   parameter bit READ_ORDER = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable_in,
   input  logic [23:0] data_in,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [7:0]  y_out,
   output logic [7:0]  cb_out,
   output logic [7:0]  cr_out,
   output logic [5:0]  out_index,
   output logic        out_last,
   output logic        overflow
);
   localparam logic [7:0] SHIFT = LEVEL_SHIFT ? LEVEL_OFFSET : 8'd0;
   ycbcr_pixel_t mem [2][BLOCK_PIXELS];
   ycbcr_pixel_t pix;
   rd_state_t state;
   logic [1:0] full, clr, set;
   logic wr_bank, rd_bank, nxt_bank, xfer, rd_done, wr_ok, wr_done, load, nxt_last;
   logic [5:0] wr_cnt, rd_cnt, nxt_cnt, nxt_addr;
   assign xfer = out_valid && out_ready;
   assign rd_done = xfer && rd_cnt == 6'd63;
   assign clr = rd_done ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;
   // a bank drained this cycle is writable this cycle
   assign wr_ok = enable_in && (!full[wr_bank] || clr[wr_bank]);
   assign wr_done = wr_ok && wr_cnt == 6'd63;
   assign set = wr_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
   assign nxt_cnt = (state == STREAM && xfer) ? rd_cnt + 6'd1 : 6'd0;
   assign nxt_bank = rd_done ? ~rd_bank : rd_bank;
   assign load = state == IDLE ? full[rd_bank] : xfer && (!rd_done || full[~rd_bank]);
   assign pix = mem[nxt_bank][nxt_addr];
   block_addr_gen #(.READ_ORDER(READ_ORDER)) u_addr (
      .cnt(nxt_cnt),
      .addr(nxt_addr),
      .last(nxt_last)
   );
   always_ff @(posedge clk)
      if (wr_ok) mem[wr_bank][wr_cnt] <= data_in;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         full <= 2'b00;
         wr_bank <= 1'b0;
         rd_bank <= 1'b0;
         wr_cnt <= 6'd0;
         rd_cnt <= 6'd0;
         out_valid <= 1'b0;
         y_out <= 8'd0;
         cb_out <= 8'd0;
         cr_out <= 8'd0;
         out_index <= 6'd0;
         out_last <= 1'b0;
         overflow <= 1'b0;
      end else begin
         full <= (full & ~clr) | set;
         if (wr_ok) wr_cnt <= wr_cnt + 6'd1;
         if (wr_done) wr_bank <= ~wr_bank;
         if (enable_in && !wr_ok) overflow <= 1'b1;
         if (rd_done) rd_bank <= ~rd_bank;
         if (load) begin
            state <= STREAM;
            out_valid <= 1'b1;
            rd_cnt <= nxt_cnt;
            out_index <= nxt_addr;
            out_last <= nxt_last;
            y_out <= pix.y ^ SHIFT;
            cb_out <= pix.cb ^ SHIFT;
            cr_out <= pix.cr ^ SHIFT;
         end else if (rd_done) begin
            state <= IDLE;
            out_valid <= 1'b0;
            rd_cnt <= 6'd0;
         end
      end
endmodule

// File: tb/tb_ycbcr_block_buffer.sv
// tb_ycbcr_block_buffer: three parameter variants driven together, checked against a block queue model
module tb_ycbcr_block_buffer;
   logic clk = 0, rst = 1, enable_in = 0, out_ready = 1;
   logic [23:0] data_in = 0;
   logic vld[3], last[3], ovf[3];
   logic [7:0] y[3], cb[3], cr[3];
   logic [5:0] idx[3];
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   for (genvar g = 0; g < 3; g++) begin : g_dut
      ycbcr_block_buffer #(.LEVEL_SHIFT(g != 2), .READ_ORDER(g == 1)) dut (
         .clk(clk), .rst(rst), .enable_in(enable_in), .data_in(data_in),
         .out_valid(vld[g]), .out_ready(out_ready), .y_out(y[g]), .cb_out(cb[g]),
         .cr_out(cr[g]), .out_index(idx[g]), .out_last(last[g]), .overflow(ovf[g])
      );
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask
   function automatic logic [7:0] shifted(input logic [7:0] v, input bit ls);
      return ls ? 8'(v - 8'd128) : v;
   endfunction
   // model: accepted pixels not yet fully replayed, oldest block first
   logic [23:0] q[$];
   logic [23:0] p;
   int k = 0, ri, xfers = 0;
   logic m_ovf = 0, prev_stall = 0;
   logic [7:0] sy[3], scb[3], scr[3];
   logic [5:0] sidx[3];
   logic slast[3];
   always @(negedge clk) begin
      if (rst) begin
         q.delete();
         k = 0;
         m_ovf = 0;
         prev_stall = 0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("overflow[%0d]", i), ovf[i], m_ovf);
            chk($sformatf("valid_agree[%0d]", i), vld[i], vld[0]);
            if (prev_stall) begin
               chk($sformatf("stall_valid[%0d]", i), vld[i], 1);
               chk($sformatf("stall_y[%0d]", i), y[i], sy[i]);
               chk($sformatf("stall_cb[%0d]", i), cb[i], scb[i]);
               chk($sformatf("stall_cr[%0d]", i), cr[i], scr[i]);
               chk($sformatf("stall_idx[%0d]", i), idx[i], sidx[i]);
               chk($sformatf("stall_last[%0d]", i), slast[i], last[i]);
            end
            if (vld[i]) begin
               chk($sformatf("block_present[%0d]", i), q.size() >= 64, 1);
               if (q.size() >= 64) begin
                  ri = (i == 1) ? (k % 8) * 8 + k / 8 : k;
                  p = q[ri];
                  chk($sformatf("y[%0d]", i), y[i], shifted(p[7:0], i != 2));
                  chk($sformatf("cb[%0d]", i), cb[i], shifted(p[15:8], i != 2));
                  chk($sformatf("cr[%0d]", i), cr[i], shifted(p[23:16], i != 2));
                  chk($sformatf("index[%0d]", i), idx[i], ri);
                  chk($sformatf("last[%0d]", i), last[i], k == 63);
               end
            end
            sy[i] = y[i];
            scb[i] = cb[i];
            scr[i] = cr[i];
            sidx[i] = idx[i];
            slast[i] = last[i];
         end
         prev_stall = vld[0] && !out_ready;
         if (vld[0] && out_ready) begin
            xfers++;
            if (k == 63) begin
               repeat (64) void'(q.pop_front());
               k = 0;
            end else k++;
         end
         if (enable_in) begin
            if (q.size() < 128) q.push_back(data_in);
            else m_ovf = 1;
         end
      end
   end
   task automatic send(input logic [23:0] d);
      enable_in = 1;
      data_in = d;
      @(posedge clk);
      #1 enable_in = 0;
   endtask
   function automatic logic [23:0] pat(input int n);
      return {8'(255 - n), 8'(n + 64), 8'(n)};
   endfunction
   int run, n, x0;
   initial begin
      #12;
      for (int i = 0; i < 3; i++) begin
         chk("reset_valid", vld[i], 0);
         chk("reset_y", y[i], 0);
         chk("reset_cb", cb[i], 0);
         chk("reset_cr", cr[i], 0);
         chk("reset_idx", idx[i], 0);
         chk("reset_last", last[i], 0);
         chk("reset_ovf", ovf[i], 0);
      end
      @(posedge clk);
      #1 rst = 0;
      for (int i = 0; i < 64; i++) send(pat(i));
      chk("latency_low", vld[0], 0);
      @(posedge clk);
      #1;
      chk("latency_high", vld[0], 1);
      chk("first_y", y[0], 8'h80);
      chk("first_cb", cb[0], 8'hC0);
      chk("first_cr", cr[0], 8'h7F);
      chk("first_idx", idx[0], 0);
      chk("raw_y", y[2], 8'h00);
      chk("raw_cb", cb[2], 8'h40);
      chk("raw_cr", cr[2], 8'hFF);
      @(posedge clk);
      #1;
      chk("second_idx", idx[0], 1);
      chk("second_y", y[0], 8'h81);
      chk("col_idx", idx[1], 8);
      chk("col_y", y[1], 8'h88);
      repeat (62) @(posedge clk);
      #1;
      chk("final_last", last[0], 1);
      chk("final_idx", idx[0], 63);
      chk("final_y", y[0], 8'hBF);
      chk("final_cr", cr[0], 8'h40);
      chk("col_final_idx", idx[1], 63);
      chk("col_final_last", last[1], 1);
      @(posedge clk);
      #1 chk("drained", vld[0], 0);
      run = 0;
      fork
         for (int i = 0; i < 192; i++) send({8'(i * 3), 8'(i * 5 + 1), 8'(i)});
         begin
            for (int t = 0; t < 400 && !vld[0]; t++) @(negedge clk);
            while (vld[0] && run < 400) begin
               run++;
               @(negedge clk);
            end
         end
      join
      chk("b2b_run", run, 192);
      chk("b2b_ovf", ovf[0], 0);
      out_ready = 0;
      for (int i = 0; i < 129; i++) send({8'(i), 8'(~i), 8'(i * 7)});
      chk("ovf_set", ovf[0], 1);
      chk("ovf_set_col", ovf[1], 1);
      chk("stalled_valid", vld[0], 1);
      out_ready = 1;
      n = 0;
      @(negedge clk);
      for (int t = 0; t < 400 && vld[0]; t++) begin
         n++;
         @(negedge clk);
      end
      chk("ovf_drain_count", n, 128);
      chk("ovf_sticky", ovf[0], 1);
      for (int i = 0; i < 64; i++) send(pat(63 - i));
      x0 = xfers;
      repeat (5) @(posedge clk);
      #1;
      for (int t = 0; t < 140; t++) begin
         out_ready = ~out_ready;
         @(posedge clk);
         #1;
      end
      out_ready = 1;
      repeat (10) @(posedge clk);
      #1;
      chk("toggle_count", xfers - x0, 64);
      chk("toggle_drained", vld[0], 0);
      out_ready = 0;
      for (int i = 0; i < 128; i++) send({8'(i + 9), 8'(i * 2), 8'(200 - i)});
      out_ready = 1;
      repeat (30) @(posedge clk);
      #1 chk("pre_rst_idx", idx[0], 30);
      rst = 1;
      out_ready = 0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("rst_valid", vld[i], 0);
         chk("rst_y", y[i], 0);
         chk("rst_cb", cb[i], 0);
         chk("rst_cr", cr[i], 0);
         chk("rst_idx", idx[i], 0);
         chk("rst_last", last[i], 0);
         chk("rst_ovf", ovf[i], 0);
      end
      @(posedge clk);
      #1 rst = 0;
      out_ready = 1;
      for (int i = 0; i < 64; i++) send(pat(i));
      @(posedge clk);
      #1;
      chk("fresh_valid", vld[0], 1);
      chk("fresh_idx", idx[0], 0);
      chk("fresh_y", y[0], 8'h80);
      repeat (70) @(posedge clk);
      #1 chk("fresh_drained", vld[0], 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
